// File: rtl/xa_bf_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xa_bf_param_pkg
// Description : Shared types and default constants for the beam-forming
//               parameter transfer engine (state encoding, default word
//               count, read latency, FIFO depth, checksum width).
// Revision    : 1.0 - initial release
// ============================================================================
package xa_bf_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [9:0] C_WORD_NUM   = 10'd256;
  localparam int         C_RD_LAT     = 3;
  localparam int         C_DATA_W     = 32;
  localparam int         C_FIFO_DEPTH = 8;
  localparam int         C_CHKSUM_W   = 32;

endpackage : xa_bf_param_pkg
`default_nettype wire

// File: rtl/xa_bf_param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xa_bf_param_fifo
// Description : Small synchronous FIFO with flush. The head word is presented
//               combinationally so the consumer sees it in the same cycle the
//               FIFO becomes non-empty.
// Ports       : i_clk156m / i_arst  clock, async active-high reset
//               i_push / i_wdata    write strobe and data
//               i_pop               remove head (ignored when empty)
//               i_flush             discard all contents (wins over push/pop)
//               o_head              current head word
//               o_empty / o_count   status
// Revision    : 1.0 - initial release
// ============================================================================
module xa_bf_param_fifo
  import xa_bf_param_pkg::*;
#(
  parameter int P_data_w = C_DATA_W,
  parameter int P_depth  = C_FIFO_DEPTH
) (
  input  logic                       i_clk156m,
  input  logic                       i_arst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [P_data_w-1:0]        i_wdata,
  output logic [P_data_w-1:0]        o_head,
  output logic                       o_empty,
  output logic [$clog2(P_depth):0]   o_count
);

  localparam int AW = $clog2(P_depth);
  localparam logic [AW:0] C_FULL = (AW+1)'(P_depth);

  logic [P_data_w-1:0] mem_q [P_depth];
  logic [P_data_w-1:0] mem_d [P_depth];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                do_pop;

  assign do_pop = i_pop && (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (i_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({i_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < P_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;

  // The upstream credit scheme must never push into a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge i_clk156m) disable iff (i_arst)
    !(i_push && !i_flush && !do_pop && (cnt_q == C_FULL)));

endmodule : xa_bf_param_fifo
`default_nettype wire

// File: rtl/xa_bf_param_xfer.sv
`default_nettype none
// ============================================================================
// Module      : xa_bf_param_xfer
// Description : Sound-speed / position-vector parameter transfer engine.
//               On i_param_start it reads P_word_num words from the source
//               RAM (fixed read latency P_rd_lat) and streams them through a
//               credit-controlled FIFO to the coefficient RAM write port over
//               valid/ready, then pulses o_param_end for one cycle.
//               i_abort returns to idle immediately, discarding everything.
// Ports       : i_clk156m, i_arst        clock, async active-high reset
//               i_param_start, i_abort   control pulses
//               o_src_rden/addr, i_src_rdata          source RAM read port
//               o_dst_valid/addr/data, i_dst_ready    destination write port
//               o_param_end, o_busy, o_chksum         status
// Options     : XA_BF_PARAM_CHKSUM_EN - when defined, o_chksum carries the
//               modulo-2^32 sum of the low 32 data bits of every delivered
//               word; otherwise o_chksum is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module xa_bf_param_xfer
  import xa_bf_param_pkg::*;
#(
  parameter logic [9:0] P_word_num   = C_WORD_NUM,
  parameter int         P_rd_lat     = C_RD_LAT,
  parameter int         P_data_w     = C_DATA_W,
  parameter int         P_fifo_depth = C_FIFO_DEPTH
) (
  input  logic                  i_clk156m,
  input  logic                  i_arst,
  input  logic                  i_param_start,
  input  logic                  i_abort,
  output logic                  o_src_rden,
  output logic [9:0]            o_src_addr,
  input  logic [P_data_w-1:0]   i_src_rdata,
  output logic                  o_dst_valid,
  output logic [9:0]            o_dst_addr,
  output logic [P_data_w-1:0]   o_dst_data,
  input  logic                  i_dst_ready,
  output logic                  o_param_end,
  output logic                  o_busy,
  output logic [C_CHKSUM_W-1:0] o_chksum
);

  localparam int CNT_W = $clog2(P_fifo_depth) + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(P_fifo_depth);

  state_e              state_q, state_d;
  logic [9:0]          rd_cnt_q, rd_cnt_d;
  logic [9:0]          wr_cnt_q, wr_cnt_d;
  logic [P_rd_lat-1:0] sr_q, sr_d;       // one bit per outstanding source read
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_empty;
  logic [P_data_w-1:0] fifo_head;
  logic                credit_ok;
  logic                handshake;
  logic                rden;
  logic                fifo_push;

  // Credits count words already committed to FIFO space: reads still in the
  // RAM pipeline plus words sitting in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < P_rd_lat; i++) begin
      inflight = inflight + CNT_W'(sr_q[i]);
    end
  end

  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < C_DEPTH;
  assign handshake = !fifo_empty && i_dst_ready;
  assign fifo_push = sr_q[P_rd_lat-1] && !i_abort;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rden     = 1'b0;

    if (handshake) begin
      wr_cnt_d = wr_cnt_q + 10'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_param_start) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      ST_READ: begin
        if (credit_ok && (rd_cnt_q < P_word_num)) begin
          rden     = 1'b1;
          rd_cnt_d = rd_cnt_q + 10'd1;
          if (rd_cnt_q == P_word_num - 10'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave on the final handshake itself so o_param_end follows it by
        // exactly one cycle.
        if (wr_cnt_d == P_word_num) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_abort) begin
      state_d  = ST_IDLE;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      rden     = 1'b0;
    end

    sr_d[0] = rden;
    for (int i = 1; i < P_rd_lat; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (i_abort) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      sr_q     <= sr_d;
    end
  end

  xa_bf_param_fifo #(
    .P_data_w (P_data_w),
    .P_depth  (P_fifo_depth)
  ) u_fifo (
    .i_clk156m (i_clk156m),
    .i_arst    (i_arst),
    .i_push    (fifo_push),
    .i_pop     (handshake),
    .i_flush   (i_abort),
    .i_wdata   (i_src_rdata),
    .o_head    (fifo_head),
    .o_empty   (fifo_empty),
    .o_count   (fifo_cnt)
  );

  assign o_src_rden  = rden;
  assign o_src_addr  = rd_cnt_q;
  assign o_dst_valid = !fifo_empty;
  assign o_dst_addr  = wr_cnt_q;
  assign o_dst_data  = fifo_head;
  assign o_busy      = (state_q != ST_IDLE);
  // An abort landing in the DONE cycle suppresses the completion pulse.
  assign o_param_end = (state_q == ST_DONE) && !i_abort;

`ifdef XA_BF_PARAM_CHKSUM_EN
  logic [C_CHKSUM_W-1:0] acc_q, acc_d;
  logic [C_CHKSUM_W-1:0] chksum_q, chksum_d;

  always_comb begin
    acc_d    = acc_q;
    chksum_d = chksum_q;
    if (handshake) begin
      acc_d = acc_q + C_CHKSUM_W'(fifo_head);
    end
    // Capture on the final handshake so the value is present with o_param_end.
    if ((state_q == ST_DRAIN) && (wr_cnt_d == P_word_num)) begin
      chksum_d = acc_d;
    end
    if ((state_q == ST_IDLE) && i_param_start) begin
      acc_d    = '0;
      chksum_d = '0;
    end
    if (i_abort) begin
      acc_d    = '0;
      chksum_d = chksum_q;
    end
  end

  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      acc_q    <= '0;
      chksum_q <= '0;
    end else begin
      acc_q    <= acc_d;
      chksum_q <= chksum_d;
    end
  end

  assign o_chksum = chksum_q;
`else
  assign o_chksum = '0;
`endif

endmodule : xa_bf_param_xfer
`default_nettype wire

// File: tb/tb_xa_bf_param_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xa_bf_param_xfer
// Description : Directed self-checking bench for xa_bf_param_xfer with a
//               16-word transfer, 3-cycle source latency and source data
//               equal to address + 0x100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xa_bf_param_xfer;

  localparam int C_N   = 16;
  localparam int C_LAT = 3;

  logic        i_clk156m = 1'b0;
  logic        i_arst;
  logic        i_param_start;
  logic        i_abort;
  logic        o_src_rden;
  logic [9:0]  o_src_addr;
  logic [31:0] i_src_rdata;
  logic        o_dst_valid;
  logic [9:0]  o_dst_addr;
  logic [31:0] o_dst_data;
  logic        i_dst_ready;
  logic        o_param_end;
  logic        o_busy;
  logic [31:0] o_chksum;

  xa_bf_param_xfer #(
    .P_word_num   (10'd16),
    .P_rd_lat     (C_LAT),
    .P_data_w     (32),
    .P_fifo_depth (8)
  ) dut (
    .i_clk156m     (i_clk156m),
    .i_arst        (i_arst),
    .i_param_start (i_param_start),
    .i_abort       (i_abort),
    .o_src_rden    (o_src_rden),
    .o_src_addr    (o_src_addr),
    .i_src_rdata   (i_src_rdata),
    .o_dst_valid   (o_dst_valid),
    .o_dst_addr    (o_dst_addr),
    .o_dst_data    (o_dst_data),
    .i_dst_ready   (i_dst_ready),
    .o_param_end   (o_param_end),
    .o_busy        (o_busy),
    .o_chksum      (o_chksum)
  );

  always #5 i_clk156m = ~i_clk156m;

  int cyc = 0;
  always @(posedge i_clk156m) cyc <= cyc + 1;

  // Source RAM: data = address + 0x100, valid C_LAT cycles after the read.
  logic [31:0] p_data [C_LAT];
  logic        p_v    [C_LAT];
  initial for (int i = 0; i < C_LAT; i++) begin p_v[i] = 1'b0; p_data[i] = '0; end
  always @(posedge i_clk156m) begin
    p_data[0] <= 32'h100 + {22'd0, o_src_addr};
    p_v[0]    <= o_src_rden;
    for (int i = 1; i < C_LAT; i++) begin
      p_data[i] <= p_data[i-1];
      p_v[i]    <= p_v[i-1];
    end
  end
  assign i_src_rdata = p_v[C_LAT-1] ? p_data[C_LAT-1] : 32'hDEAD_BEEF;

  // Monitor (samples on the falling edge).
  logic [9:0]  q_addr [$];
  logic [31:0] q_data [$];
  int          first_v, last_hs, pe_cnt, pe_cyc, rden_cnt, credit_err, stab_err;
  logic [31:0] pe_chk;
  logic        prev_stall;
  logic [9:0]  prev_addr;
  logic [31:0] prev_data;

  task automatic mon_clear();
    q_addr.delete();
    q_data.delete();
    first_v    = -1;
    last_hs    = -1;
    pe_cnt     = 0;
    pe_cyc     = -1;
    rden_cnt   = 0;
    credit_err = 0;
    stab_err   = 0;
    pe_chk     = '0;
    prev_stall = 1'b0;
  endtask

  always @(negedge i_clk156m) begin
    if (!i_arst) begin
      if (o_src_rden && (rden_cnt - q_addr.size() >= 8)) credit_err++;
      if (o_src_rden) rden_cnt++;
      if (prev_stall && (!o_dst_valid || o_dst_addr != prev_addr || o_dst_data != prev_data))
        stab_err++;
      prev_stall = o_dst_valid && !i_dst_ready;
      prev_addr  = o_dst_addr;
      prev_data  = o_dst_data;
      if (o_dst_valid && first_v < 0) first_v = cyc;
      if (o_dst_valid && i_dst_ready) begin
        q_addr.push_back(o_dst_addr);
        q_data.push_back(o_dst_data);
        last_hs = cyc;
      end
      if (o_param_end) begin
        pe_cnt++;
        pe_cyc = cyc;
        pe_chk = o_chksum;
      end
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk156m);
    #1;
  endtask

  task automatic start_xfer(output int t0);
    i_param_start = 1'b1;
    t0 = cyc;
    tick();
    i_param_start = 1'b0;
  endtask

  task automatic wait_pe(input int budget);
    for (int k = 0; k < budget && pe_cnt == 0; k++) tick();
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic chk_words(input string tg);
    chk({tg, "_count"}, q_addr.size(), C_N);
    for (int i = 0; i < q_addr.size() && i < C_N; i++) begin
      chk($sformatf("%s_addr%0d", tg, i), {22'd0, q_addr[i]}, i);
      chk($sformatf("%s_data%0d", tg, i), q_data[i], 32'h100 + i);
    end
  endtask

  logic [31:0] exp_chk;
  int t0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef XA_BF_PARAM_CHKSUM_EN
    exp_chk = 32'h1078;
`else
    exp_chk = 32'h0;
`endif
    i_arst = 1'b1; i_param_start = 1'b0; i_abort = 1'b0; i_dst_ready = 1'b1;
    mon_clear();
    repeat (3) @(posedge i_clk156m);
    @(negedge i_clk156m);
    chk("rst_busy",  o_busy,      0);
    chk("rst_rden",  o_src_rden,  0);
    chk("rst_valid", o_dst_valid, 0);
    chk("rst_pend",  o_param_end, 0);
    chk("rst_addr",  o_dst_addr,  0);
    chk("rst_chk",   o_chksum,    0);
    tick();
    i_arst = 1'b0;
    tick();

    // 1: basic transfer, ready held high
    mon_clear();
    start_xfer(t0);
    wait_pe(200);
    chk_words("t1");
    chk("t1_first_valid_lat", first_v - t0, 2 + C_LAT);
    chk("t1_stream_span", last_hs - first_v, C_N - 1);
    chk("t1_pe_count", pe_cnt, 1);
    chk("t1_pe_delay", pe_cyc - last_hs, 1);
    chk("t1_chksum", pe_chk, exp_chk);
    chk("t1_busy_after", o_busy, 0);

    // 2: backpressure; toggling ready, then ready low to exhaust credits
    mon_clear();
    start_xfer(t0);
    for (int k = 0; k < 12; k++) begin
      i_dst_ready = (k % 2 == 0);
      tick();
    end
    i_dst_ready = 1'b0;
    repeat (20) tick();
    chk("t2_credit_stall", rden_cnt - q_addr.size(), 8);
    i_dst_ready = 1'b1;
    wait_pe(200);
    chk_words("t2");
    chk("t2_credit_err", credit_err, 0);
    chk("t2_stable_err", stab_err, 0);
    chk("t2_pe_count", pe_cnt, 1);

    // 3: abort on the 6th handshake, then a clean transfer
    mon_clear();
    start_xfer(t0);
    while (cyc < t0 + 2 + C_LAT + 5) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    @(negedge i_clk156m);
    chk("t3_busy_after_abort", o_busy, 0);
    chk("t3_valid_after_abort", o_dst_valid, 0);
    tick();
    chk("t3_hs_before_abort", q_addr.size(), 6);
    mon_clear();
    repeat (10) tick();
    chk("t3_no_late_words", q_addr.size(), 0);
    chk("t3_no_rden", rden_cnt, 0);
    chk("t3_no_pe", pe_cnt, 0);
    mon_clear();
    start_xfer(t0);
    wait_pe(200);
    chk_words("t3r");
    chk("t3r_pe_count", pe_cnt, 1);

    // 4: second start while busy is ignored
    mon_clear();
    start_xfer(t0);
    while (cyc < t0 + 4) tick();
    i_param_start = 1'b1;
    tick();
    i_param_start = 1'b0;
    wait_pe(200);
    repeat (10) tick();
    chk("t4_words", q_addr.size(), C_N);
    chk("t4_rden", rden_cnt, C_N);
    chk("t4_pe_count", pe_cnt, 1);
    chk("t4_busy_after", o_busy, 0);

    // 5: abort and start together in idle
    mon_clear();
    i_abort = 1'b1;
    i_param_start = 1'b1;
    tick();
    i_abort = 1'b0;
    i_param_start = 1'b0;
    @(negedge i_clk156m);
    chk("t5_busy", o_busy, 0);
    repeat (6) tick();
    chk("t5_no_rden", rden_cnt, 0);
    chk("t5_no_pe", pe_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_xa_bf_param_xfer
`default_nettype wire

// File: doc/xa_bf_param_xfer.md
Name: xa_bf_param_xfer

Overview:
Sound-speed / position-vector parameter transfer engine for the beam forming stage. It sits directly downstream of the BF control block: it consumes that block's param-start pulse and returns the param-end pulse the control block waits on before leaving its transfer-wait state. It reads P_word_num words from the parameter source RAM (fixed read latency) and streams them over a valid/ready interface into the beamformer coefficient RAM write port, buffering through a small credit-controlled FIFO.

Parameters:
P_word_num, 10'd256, words per transfer (1..1023)
P_rd_lat, 3, source RAM read latency in cycles (1..6)
P_data_w, 32, data width
P_fifo_depth, 8, return FIFO depth (power of 2, must be >= P_rd_lat+2)

Ports:
i_clk156m  input  1  clock
i_arst  input  1  reset
i_param_start  input  1  transfer start pulse from BF control
i_abort  input  1  abort pulse (frame_time change detected upstream)
o_src_rden  output  1  source RAM read enable
o_src_addr  output  10  source RAM read address
i_src_rdata  input  P_data_w  source read data, valid P_rd_lat cycles after o_src_rden
o_dst_valid  output  1  destination write valid
o_dst_addr  output  10  destination word address
o_dst_data  output  P_data_w  destination write data
i_dst_ready  input  1  destination accepts when valid&ready
o_param_end  output  1  transfer complete pulse to BF control
o_busy  output  1  transfer in progress
o_chksum  output  32  transfer checksum (optional feature)

Behaviour:
- Interface: clock i_clk156m; reset i_arst, asynchronous, active-high. All outputs reset to 0; state reset to ST_IDLE.
- States: ST_IDLE, ST_READ, ST_DRAIN, ST_DONE.
- ST_IDLE: i_param_start=1 -> ST_READ; read counter and write counter cleared. o_busy=0.
- ST_READ: o_src_rden=1 in each cycle where (in-flight reads + FIFO occupancy) < P_fifo_depth and rd_cnt < P_word_num; o_src_addr = rd_cnt, rd_cnt increments per issued read. When the last read (rd_cnt = P_word_num-1) issues -> ST_DRAIN.
- In-flight tracking: a P_rd_lat-deep valid shift register; its output pushes i_src_rdata into the FIFO. The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Destination: o_dst_valid = FIFO not empty; o_dst_data = FIFO head; o_dst_addr = wr_cnt. On valid&ready: pop, wr_cnt+1. o_dst_data and o_dst_addr hold stable while valid&!ready.
- ST_DRAIN: -> ST_DONE when wr_cnt = P_word_num (final handshake completed).
- ST_DONE: o_param_end=1 for exactly one cycle; -> ST_IDLE.
- o_busy=1 in ST_READ, ST_DRAIN, ST_DONE.
- Latency with ready held high: start at cycle 0, first rden at cycle 1, first o_dst_valid at cycle 2+P_rd_lat. One word per cycle sustained. o_param_end asserts 1 cycle after the last handshake.
- i_param_start while o_busy=1: ignored.
- i_abort: from any state -> ST_IDLE next cycle. FIFO flushed, in-flight shift register cleared (late returns discarded), counters cleared, o_param_end not asserted. If i_abort and i_param_start arrive in the same cycle, abort wins and no transfer starts.
- Counter widths: 10 bits for rd_cnt and wr_cnt; no wrap, because of the P_word_num bound.

Optional Feature:
XA_BF_PARAM_CHKSUM_EN: when defined, a 32-bit modulo-2^32 sum of the low 32 data bits is accumulated over every handshaken word. It is cleared on start and on abort. o_chksum is updated in the same cycle o_param_end asserts and holds until the next start. When not defined, o_chksum is tied to 0 and no accumulator is built.

Decomposition:
- Package xa_bf_param_pkg: state encodings, default constants (word count, read latency, FIFO depth), checksum width.
- One sub-module: xa_bf_param_fifo, a synchronous FIFO with push, pop, flush, empty, and count outputs; combinational head output.

Test Plan:
1. Basic transfer: P_word_num=16, P_rd_lat=3, ready=1, source[i]=i+0x100. Start at cycle 0 -> dst_valid first at cycle 5; addresses 0..15 carry data 0x100..0x10F, one word per cycle; a single o_param_end pulse 1 cycle after the last handshake.
2. Backpressure: ready toggles 1/0 every cycle, then is held low 20 cycles. No rden issued once credits reach 8; no data lost or duplicated; 16 words arrive in order.
3. Abort mid-transfer: i_abort at the 6th handshake -> ST_IDLE next cycle, o_dst_valid=0, no o_param_end. A new start then delivers addresses 0..15 with no stale data.
4. Start while busy: a second i_param_start at cycle 4 is ignored; exactly 16 words and one o_param_end result.
5. Simultaneous abort+start in ST_IDLE: remains in ST_IDLE, no rden.
6. XA_BF_PARAM_CHKSUM_EN defined, 16 words with data i+0x100 -> o_chksum=0x1078 when o_param_end asserts. Without the macro, o_chksum=0.
